// File: rtl/mem_nr1w_bypass.sv
// mem_nr1w_bypass
//   Multi-read, single-write register-file memory with optional write-to-read
//   forwarding, byte-enabled writes, and a self-clearing init sequence that
//   zeroes every entry after reset before any access is accepted.
//
// Parameters
//   DEPTH_LOG2   : address width; ELEMENTS = 2**DEPTH_LOG2 entries
//   WIDTH        : data width in bits (multiple of 8)
//   NUM_READ     : number of independent read ports (1..4)
//   READ_LATENCY : 1 or 2 cycles from read strobe edge to read_valid
//   BYPASS       : 1 = same-cycle write forwarded to a colliding read
//
// Ports
//   clk        : sole clock, rising edge
//   resetn     : asynchronous active-low reset
//   read_addr  : NUM_READ packed addresses, port p at [p*DEPTH_LOG2 +: DEPTH_LOG2]
//   read       : per-port read strobe
//   read_data  : NUM_READ packed data words, port p at [p*WIDTH +: WIDTH]
//   read_valid : per-port one-cycle pulse qualifying read_data
//   write_addr : write address
//   write      : write strobe
//   write_be   : byte enables, bit b covers data bits [8b+7:8b]
//   write_data : write data
//   init_busy  : high while the memory is being cleared
module mem_nr1w_bypass #(
  parameter int DEPTH_LOG2   = 4,
  parameter int WIDTH        = 32,
  parameter int NUM_READ     = 2,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS       = 1
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NUM_READ*DEPTH_LOG2-1:0] read_addr,
  input  logic [NUM_READ-1:0]            read,
  output logic [NUM_READ*WIDTH-1:0]      read_data,
  output logic [NUM_READ-1:0]            read_valid,
  input  logic [DEPTH_LOG2-1:0]          write_addr,
  input  logic                           write,
  input  logic [WIDTH/8-1:0]             write_be,
  input  logic [WIDTH-1:0]               write_data,
  output logic                           init_busy
);

  localparam int ELEMENTS = 2**DEPTH_LOG2;
  localparam int NBYTES   = WIDTH/8;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state;
  logic [DEPTH_LOG2-1:0]   init_cnt;
  logic [WIDTH-1:0]        storage [ELEMENTS];
  logic                    ready;

  // Replace the bytes of old_word selected by be with the matching bytes of new_word.
  function automatic logic [WIDTH-1:0] merge_bytes(
    input logic [WIDTH-1:0]  old_word,
    input logic [WIDTH-1:0]  new_word,
    input logic [NBYTES-1:0] be
  );
    logic [WIDTH-1:0] merged;
    merged = old_word;
    for (int b = 0; b < NBYTES; b++) begin
      if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

  // Controller: INIT walks init_cnt over every entry, then parks in READY.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= INIT;
      init_cnt  <= '0;
      init_busy <= 1'b1;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + DEPTH_LOG2'(1);
      if (init_cnt == DEPTH_LOG2'(ELEMENTS - 1)) begin
        state     <= READY;
        init_busy <= 1'b0;
      end
    end
  end

  assign ready = (state == READY);

  // Storage has no reset; INIT is what gives it a defined (zero) value.
  always_ff @(posedge clk) begin
    if (!ready) begin
      storage[init_cnt] <= '0;
    end else if (write) begin
      storage[write_addr] <= merge_bytes(storage[write_addr], write_data, write_be);
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_port
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic                  accept;
    logic                  hit;
    logic [WIDTH-1:0]      rd_word;
    logic [WIDTH-1:0]      data_p0;
    logic                  vld_p0;

    assign rd_addr = read_addr[p*DEPTH_LOG2 +: DEPTH_LOG2];
    assign accept  = ready & read[p];
    assign hit     = (BYPASS != 0) && write && (rd_addr == write_addr);

    // Forwarded word equals what storage will hold after this edge's write.
    always_comb begin
      rd_word = storage[rd_addr];
      if (hit) rd_word = merge_bytes(storage[rd_addr], write_data, write_be);
    end

    // Stage p0: capture on the strobe edge; data holds until the next accepted read.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        data_p0 <= '0;
        vld_p0  <= 1'b0;
      end else begin
        vld_p0 <= accept;
        if (accept) data_p0 <= rd_word;
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic [WIDTH-1:0] data_p1;
      logic             vld_p1;

      // Stage p1: second register, advances only when p0 carries a result.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          data_p1 <= '0;
          vld_p1  <= 1'b0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) data_p1 <= data_p0;
        end
      end

      assign read_data[p*WIDTH +: WIDTH] = data_p1;
      assign read_valid[p]               = vld_p1;
    end else begin : g_lat1
      assign read_data[p*WIDTH +: WIDTH] = data_p0;
      assign read_valid[p]               = vld_p0;
    end
  end

endmodule

// File: tb/tb_mem_nr1w_bypass.sv
// Testbench for mem_nr1w_bypass: two instances share all inputs.
//   dut1 : READ_LATENCY=1, BYPASS=1 (defaults)
//   dut2 : READ_LATENCY=2, BYPASS=0
module tb_mem_nr1w_bypass;

  logic        clk;
  logic        resetn;
  logic [7:0]  read_addr;
  logic [1:0]  read;
  logic [3:0]  write_addr;
  logic        write;
  logic [3:0]  write_be;
  logic [31:0] write_data;

  logic [63:0] rd1, rd2;
  logic [1:0]  rv1, rv2;
  logic        busy1, busy2;

  int checks;
  int failures;

  mem_nr1w_bypass #(
    .DEPTH_LOG2(4), .WIDTH(32), .NUM_READ(2), .READ_LATENCY(1), .BYPASS(1)
  ) dut1 (
    .clk(clk), .resetn(resetn), .read_addr(read_addr), .read(read),
    .read_data(rd1), .read_valid(rv1), .write_addr(write_addr), .write(write),
    .write_be(write_be), .write_data(write_data), .init_busy(busy1)
  );

  mem_nr1w_bypass #(
    .DEPTH_LOG2(4), .WIDTH(32), .NUM_READ(2), .READ_LATENCY(2), .BYPASS(0)
  ) dut2 (
    .clk(clk), .resetn(resetn), .read_addr(read_addr), .read(read),
    .read_data(rd2), .read_valid(rv2), .write_addr(write_addr), .write(write),
    .write_be(write_be), .write_data(write_data), .init_busy(busy2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    write = 1'b1; write_addr = a; write_data = d; write_be = be;
    tick();
    write = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    read = 2'b11; read_addr = 8'h00;
    tick(); tick();
    checks++;
    if (rv1 !== 2'b00 || rv2 !== 2'b00) begin
      failures++; $display("FAIL reset_valid got=%b/%b exp=00/00", rv1, rv2);
    end
    checks++;
    if (rd1 !== 64'h0 || rd2 !== 64'h0) begin
      failures++; $display("FAIL reset_data got=%h/%h exp=0", rd1, rd2);
    end
    checks++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
      failures++; $display("FAIL reset_busy got=%b/%b exp=1/1", busy1, busy2);
    end
    read = 2'b00;
  endtask

  // Release reset and count cycles of init_busy; a read held through INIT must be ignored.
  task automatic run_init(input string tag, input logic hold_read);
    int cnt;
    logic seen_valid;
    cnt = 0; seen_valid = 1'b0;
    read = {1'b0, hold_read}; read_addr = 8'h00;
    resetn = 1'b1;
    while (1) begin
      tick();
      cnt++;
      if (rv1 !== 2'b00 || rv2 !== 2'b00) seen_valid = 1'b1;
      if (busy1 !== 1'b1 || cnt >= 40) break;
    end
    checks++;
    if (cnt != 16) begin
      failures++; $display("FAIL %s_init_cycles got=%0d exp=16", tag, cnt);
    end
    checks++;
    if (busy2 !== 1'b0) begin
      failures++; $display("FAIL %s_init_busy2 got=%b exp=0", tag, busy2);
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      failures++; $display("FAIL %s_init_read_ignored got=1 exp=0", tag);
    end
    read = 2'b00;
    tick();
    checks++;
    if (rv1 !== 2'b00 || rv2 !== 2'b00) begin
      failures++; $display("FAIL %s_init_last_read got=%b/%b exp=00/00", tag, rv1, rv2);
    end
  endtask

  task automatic test_init_clear();
    for (int a = 0; a < 16; a++) begin
      read = 2'b01; read_addr = {4'h0, 4'(a)};
      tick();
      checks++;
      if (rv1[0] !== 1'b1 || rd1[31:0] !== 32'h0) begin
        failures++; $display("FAIL init_clear_a%0d got=%b/%h exp=1/00000000", a, rv1[0], rd1[31:0]);
      end
    end
    read = 2'b00;
    tick();
  endtask

  task automatic test_byte_enable();
    do_write(4'd3, 32'hAABBCCDD, 4'hF);
    do_write(4'd3, 32'h11223344, 4'b0101);
    read = 2'b01; read_addr = 8'h03;
    tick();
    read = 2'b00;
    checks++;
    if (rv1 !== 2'b01 || rd1[31:0] !== 32'hAA22CC44) begin
      failures++; $display("FAIL be_lat1 got=%b/%h exp=01/aa22cc44", rv1, rd1[31:0]);
    end
    checks++;
    if (rv2 !== 2'b00) begin
      failures++; $display("FAIL be_lat2_early got=%b exp=00", rv2);
    end
    tick();
    checks++;
    if (rv2 !== 2'b01 || rd2[31:0] !== 32'hAA22CC44) begin
      failures++; $display("FAIL be_lat2 got=%b/%h exp=01/aa22cc44", rv2, rd2[31:0]);
    end
    checks++;
    if (rv1 !== 2'b00 || rd1[31:0] !== 32'hAA22CC44) begin
      failures++; $display("FAIL be_hold got=%b/%h exp=00/aa22cc44", rv1, rd1[31:0]);
    end
    do_write(4'd3, 32'hFFFFFFFF, 4'h0);
    read = 2'b01; read_addr = 8'h03;
    tick();
    read = 2'b00;
    checks++;
    if (rv1 !== 2'b01 || rd1[31:0] !== 32'hAA22CC44) begin
      failures++; $display("FAIL be_zero got=%b/%h exp=01/aa22cc44", rv1, rd1[31:0]);
    end
    tick();
  endtask

  task automatic test_bypass();
    write = 1'b1; write_addr = 4'd5; write_data = 32'hDEADBEEF; write_be = 4'hF;
    read = 2'b10; read_addr = 8'h50;
    tick();
    write = 1'b0; read = 2'b00;
    checks++;
    if (rv1 !== 2'b10 || rd1[63:32] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL bypass_on got=%b/%h exp=10/deadbeef", rv1, rd1[63:32]);
    end
    tick();
    checks++;
    if (rv2 !== 2'b10 || rd2[63:32] !== 32'h0) begin
      failures++; $display("FAIL bypass_off got=%b/%h exp=10/00000000", rv2, rd2[63:32]);
    end
    // Partial-byte collision on a cleared entry.
    write = 1'b1; write_addr = 4'd6; write_data = 32'h12345678; write_be = 4'b0011;
    read = 2'b01; read_addr = 8'h06;
    tick();
    write = 1'b0; read = 2'b00;
    checks++;
    if (rv1 !== 2'b01 || rd1[31:0] !== 32'h00005678) begin
      failures++; $display("FAIL bypass_partial got=%b/%h exp=01/00005678", rv1, rd1[31:0]);
    end
    tick();
    checks++;
    if (rv2 !== 2'b01 || rd2[31:0] !== 32'h0) begin
      failures++; $display("FAIL bypass_partial_off got=%b/%h exp=01/00000000", rv2, rd2[31:0]);
    end
    // The write itself landed in both instances.
    read = 2'b10; read_addr = 8'h50;
    tick();
    read = 2'b00;
    tick();
    checks++;
    if (rv2 !== 2'b10 || rd2[63:32] !== 32'hDEADBEEF || rd1[63:32] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL bypass_stored got=%h/%h exp=deadbeef", rd1[63:32], rd2[63:32]);
    end
  endtask

  task automatic test_multi_port();
    do_write(4'd2, 32'h12345678, 4'hF);
    do_write(4'd9, 32'h9ABCDEF0, 4'hF);
    read = 2'b11; read_addr = 8'h92;
    tick();
    checks++;
    if (rv1 !== 2'b11 || rd1 !== 64'h9ABCDEF0_12345678) begin
      failures++; $display("FAIL mp_lat1 got=%b/%h exp=11/9abcdef012345678", rv1, rd1);
    end
    read = 2'b11; read_addr = 8'h99;
    tick();
    read = 2'b00;
    checks++;
    if (rv1 !== 2'b11 || rd1 !== 64'h9ABCDEF0_9ABCDEF0) begin
      failures++; $display("FAIL mp_same_addr got=%b/%h exp=11/9abcdef09abcdef0", rv1, rd1);
    end
    checks++;
    if (rv2 !== 2'b11 || rd2 !== 64'h9ABCDEF0_12345678) begin
      failures++; $display("FAIL mp_lat2 got=%b/%h exp=11/9abcdef012345678", rv2, rd2);
    end
    tick();
    checks++;
    if (rv2 !== 2'b11 || rd2 !== 64'h9ABCDEF0_9ABCDEF0) begin
      failures++; $display("FAIL mp_lat2_same got=%b/%h exp=11/9abcdef09abcdef0", rv2, rd2);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 8; a++) do_write(4'(a), 32'hC0DE0000 | 32'(a), 4'hF);
    for (int a = 0; a < 8; a++) begin
      read = 2'b01; read_addr = {4'h0, 4'(a)};
      tick();
      checks++;
      if (rv1 !== 2'b01 || rd1[31:0] !== (32'hC0DE0000 | 32'(a))) begin
        failures++; $display("FAIL b2b_lat1_a%0d got=%b/%h", a, rv1, rd1[31:0]);
      end
      checks++;
      if (a == 0) begin
        if (rv2 !== 2'b00) begin
          failures++; $display("FAIL b2b_lat2_first got=%b exp=00", rv2);
        end
      end else if (rv2 !== 2'b01 || rd2[31:0] !== (32'hC0DE0000 | 32'(a - 1))) begin
        failures++; $display("FAIL b2b_lat2_a%0d got=%b/%h", a - 1, rv2, rd2[31:0]);
      end
    end
    read = 2'b00;
    tick();
    checks++;
    if (rv2 !== 2'b01 || rd2[31:0] !== 32'hC0DE0007 || rv1 !== 2'b00) begin
      failures++; $display("FAIL b2b_tail got=%b/%h lat1v=%b exp=01/c0de0007/00", rv2, rd2[31:0], rv1);
    end
    tick();
    checks++;
    if (rv2 !== 2'b00 || rd2[31:0] !== 32'hC0DE0007) begin
      failures++; $display("FAIL b2b_end got=%b/%h exp=00/c0de0007", rv2, rd2[31:0]);
    end
  endtask

  task automatic test_reset_midop();
    read = 2'b11; read_addr = 8'h32;
    tick();
    // dut2 now holds the read in its first stage; abort it.
    resetn = 1'b0;
    #1;
    checks++;
    if (rv1 !== 2'b00 || rv2 !== 2'b00 || rd1 !== 64'h0 || rd2 !== 64'h0) begin
      failures++; $display("FAIL midop_abort got=%b/%b %h/%h exp=00/00 0/0", rv1, rv2, rd1, rd2);
    end
    checks++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
      failures++; $display("FAIL midop_busy got=%b/%b exp=1/1", busy1, busy2);
    end
    tick(); tick();
    checks++;
    if (rv1 !== 2'b00 || rv2 !== 2'b00) begin
      failures++; $display("FAIL midop_held got=%b/%b exp=00/00", rv1, rv2);
    end
    read = 2'b00;
    run_init("midop", 1'b0);
    read = 2'b11; read_addr = 8'h23;
    tick();
    read = 2'b00;
    checks++;
    if (rv1 !== 2'b11 || rd1 !== 64'h0) begin
      failures++; $display("FAIL midop_cleared got=%b/%h exp=11/0", rv1, rd1);
    end
    tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    clk = 1'b0; resetn = 1'b0;
    read = 2'b00; read_addr = 8'h00;
    write = 1'b0; write_addr = 4'h0; write_be = 4'h0; write_data = 32'h0;
    test_reset();
    run_init("first", 1'b1);
    test_init_clear();
    test_byte_enable();
    test_bypass();
    test_multi_port();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
